core_wb_arbiter: RTL and testbench
==================================

// Module: core_wb_arbiter
// PURPOSE
//  Owns the single write port of the core register file. Arbitrates two writeback
//  requesters (req0 = ALU pipe, req1 = LSU/MDU long-latency unit) onto i_we/i_waddr/i_wdata.
//  Keeps a 32-entry pending-write scoreboard and raises a decode stall on RAW hazards.
//  Sits between the execute/memory stages and the regfile, beside the decoder.
// PARAMETERS
//  MAX_WAIT  4  consecutive denied cycles of req1 before forced grant (WB_AGING_EN only)
//  AGE_W     3  width of the req1 age counter; must satisfy 2**AGE_W > MAX_WAIT
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  i_wb0_valid   in   1   req0 has a writeback
//  o_wb0_ready   out  1   req0 granted this cycle
//  i_wb0_addr    in   5   req0 destination register
//  i_wb0_data    in   32  req0 writeback data
//  i_wb1_valid   in   1   req1 has a writeback
//  o_wb1_ready   out  1   req1 granted this cycle
//  i_wb1_addr    in   5   req1 destination register
//  i_wb1_data    in   32  req1 writeback data
//  i_issue       in   1   decode issues an instruction that will write i_issue_rd
//  i_issue_rd    in   5   destination of the issued instruction
//  i_re1/i_re2   in   1   decode reads source 1 / source 2
//  i_raddr1/2    in   5   decode source addresses
//  o_stall       out  1   RAW hazard: hold decode this cycle
//  o_busy        out  32  scoreboard, bit n = write to xn pending
//  o_we          out  1   regfile write enable
//  o_waddr       out  5   regfile write address
//  o_wdata       out  32  regfile write data
// BEHAVIOUR
//  Reset (async, rst_n=0): o_we=0, o_waddr=0, o_wdata=0, o_busy=0, age counter=0.
//   Combinational outputs settle to o_wb0_ready=0, o_wb1_ready=0, o_stall=0 with valids low.
//  Grant is combinational from the valids. Readys are never asserted without valid.
//   At most one grant per cycle.
//  Priority: req0 wins when both are valid, except a forced req1 grant (see CONFIGURATION).
//  Handshake: a transfer occurs when valid && ready. A requester holds addr/data stable
//   while valid && !ready. Valid may not drop before it is granted.
//  Output stage: one registered stage with 1-cycle latency.
//   On the edge after a grant: o_we=1, o_waddr=winner addr, o_wdata=winner data.
//   With no grant: o_we=0, o_waddr/o_wdata hold their previous value.
//  Writes to x0: the grant and handshake occur normally, but o_we stays 0.
//  Scoreboard:
//   - i_issue with i_issue_rd!=0 sets busy[rd] at the edge. x0 is never marked.
//   - A grant clears busy[winner addr] at the same edge.
//   - If set and clear hit the same register in the same cycle, the set wins.
//  Stall: o_stall = (i_re1 && i_raddr1!=0 && busy[i_raddr1])
//                 | (i_re2 && i_raddr2!=0 && busy[i_raddr2]).
//   busy clears at the grant edge, so the stall drops in the cycle o_we presents the data.
//   The regfile's same-cycle write forwarding then supplies the value.
//  Same address from both requesters in one cycle: only the winner is written.
//   The loser's write lands in a later cycle and is the final value.
//  Reset mid-operation: every in-flight write and every pending bit is discarded.
// CONFIGURATION
//  WB_AGING_EN defined:
//   - The age counter increments each cycle i_wb1_valid && !o_wb1_ready, saturating.
//   - It clears on a req1 grant or when i_wb1_valid=0.
//   - When the counter reaches MAX_WAIT, req1 wins the next arbitration even if req0 is valid.
//     req0 then sees ready=0 and holds.
//  WB_AGING_EN undefined: strict req0 priority. req1 can starve. No age counter exists.
// TESTING
//  1. Reset, then wb0 valid addr=5 data=0xA5A5A5A5
//     -> ready0 same cycle; next cycle o_we=1, o_waddr=5, o_wdata=0xA5A5A5A5.
//  2. wb0 and wb1 both valid every cycle (addr 3 and 4)
//     -> aging: req1 granted on cycle MAX_WAIT+1=5; no aging: req1 never granted.
//  3. issue rd=7; next cycle decode reads raddr1=7 -> o_stall=1;
//     wb1 writes 7 -> stall drops in the o_we cycle; busy[7]=0.
//  4. wb0 valid addr=0 data=0xFFFFFFFF -> ready0=1, o_we stays 0.
//     Issue rd=0 -> busy stays 0, no stall.
//  5. Same cycle: issue rd=9 and grant wb0 addr=9 -> busy[9]=1 afterwards.
//  6. Set busy[12], assert wb1 valid, pulse rst_n low mid-transfer
//     -> o_we=0, o_busy=0, age=0 immediately.

Source files
------------

// File: rtl/core_wb_arbiter_if.sv
// Writeback/decode bundle between the two writeback requesters, decode and core_wb_arbiter.
// master: requesters + decode side; slave: the arbiter.
interface core_wb_arbiter_if;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic          i_wb0_valid;
    logic          o_wb0_ready;
    logic [AW-1:0] i_wb0_addr;
    logic [DW-1:0] i_wb0_data;
    logic          i_wb1_valid;
    logic          o_wb1_ready;
    logic [AW-1:0] i_wb1_addr;
    logic [DW-1:0] i_wb1_data;
    logic          i_issue;
    logic [AW-1:0] i_issue_rd;
    logic          i_re1;
    logic          i_re2;
    logic [AW-1:0] i_raddr1;
    logic [AW-1:0] i_raddr2;
    logic          o_stall;
    logic [NREG-1:0] o_busy;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;

    modport master (
        output i_wb0_valid, i_wb0_addr, i_wb0_data,
        output i_wb1_valid, i_wb1_addr, i_wb1_data,
        output i_issue, i_issue_rd, i_re1, i_re2, i_raddr1, i_raddr2,
        input  o_wb0_ready, o_wb1_ready, o_stall, o_busy, o_we, o_waddr, o_wdata
    );

    modport slave (
        input  i_wb0_valid, i_wb0_addr, i_wb0_data,
        input  i_wb1_valid, i_wb1_addr, i_wb1_data,
        input  i_issue, i_issue_rd, i_re1, i_re2, i_raddr1, i_raddr2,
        output o_wb0_ready, o_wb1_ready, o_stall, o_busy, o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard and RAW stall.
// Optional feature macro WB_AGING_EN: age counter forces a req1 grant after MAX_WAIT denials.
module core_wb_arbiter
`ifdef WB_AGING_EN
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AGE_W    = 3
)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    core_wb_arbiter_if.slave   bus
);
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    logic            grant0_c;
    logic            grant1_c;
    logic            force1_c;
    logic [AW-1:0]   win_addr_c;
    logic [DW-1:0]   win_data_c;

    logic            we_q,    we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREG-1:0] busy_q,  busy_d;

`ifdef WB_AGING_EN
    logic [AGE_W-1:0] age_q, age_d;

    assign force1_c = bus.i_wb1_valid && (age_q >= AGE_W'(MAX_WAIT));

    // Count consecutive denied req1 cycles, saturating; any gap or grant restarts it.
    always_comb begin
        age_d = '0;
        if (bus.i_wb1_valid && !grant1_c) begin
            age_d = (age_q == '1) ? age_q : age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign force1_c = 1'b0;
`endif

    // Single grant per cycle; req0 first unless req1 has aged out.
    always_comb begin
        grant1_c   = bus.i_wb1_valid && (!bus.i_wb0_valid || force1_c);
        grant0_c   = bus.i_wb0_valid && !grant1_c;
        win_addr_c = grant1_c ? bus.i_wb1_addr : bus.i_wb0_addr;
        win_data_c = grant1_c ? bus.i_wb1_data : bus.i_wb0_data;
    end

    assign bus.o_wb0_ready = grant0_c;
    assign bus.o_wb1_ready = grant1_c;

    // Clear before set so an issue to the register being retired keeps it pending.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        if (grant0_c || grant1_c) begin
            we_d               = (win_addr_c != '0);
            waddr_d            = win_addr_c;
            wdata_d            = win_data_c;
            busy_d[win_addr_c] = 1'b0;
        end
        if (bus.i_issue && (bus.i_issue_rd != '0)) begin
            busy_d[bus.i_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    // x0 never goes busy, so its explicit exclusion only matters after reset-free X paths.
    assign bus.o_stall = (bus.i_re1 && (bus.i_raddr1 != '0) && busy_q[bus.i_raddr1])
                       | (bus.i_re2 && (bus.i_raddr2 != '0) && busy_q[bus.i_raddr2]);

    assign bus.o_busy  = busy_q;
    assign bus.o_we    = we_q;
    assign bus.o_waddr = waddr_q;
    assign bus.o_wdata = wdata_q;
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Randomized self-checking bench for core_wb_arbiter against a rule-level reference model.
module tb_core_wb_arbiter;
`ifdef WB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif
    localparam int MAX_WAIT = 4;
    localparam int AGE_W    = 3;
    localparam int AGE_MAX  = (1 << AGE_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    core_wb_arbiter_if bus();

`ifdef WB_AGING_EN
    core_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .AGE_W(AGE_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    core_wb_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Reference model: architectural pending set, last regfile write, req1 wait length.
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_age;

    task automatic model_reset();
        m_busy = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_age = 0;
    endtask

    task automatic model_grants(output logic g0, output logic g1);
        logic forced;
        forced = AGING && bus.i_wb1_valid && (m_age >= MAX_WAIT);
        g1 = bus.i_wb1_valid && (forced || !bus.i_wb0_valid);
        g0 = bus.i_wb0_valid && !g1;
    endtask

    function automatic logic model_stall();
        logic s1, s2;
        s1 = bus.i_re1 && (bus.i_raddr1 != 0) && m_busy[bus.i_raddr1];
        s2 = bus.i_re2 && (bus.i_raddr2 != 0) && m_busy[bus.i_raddr2];
        return s1 | s2;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic g0, g1, iss;
        logic [4:0] a, rd;
        logic [31:0] d;
        logic v1;
        model_grants(g0, g1);
        a   = g1 ? bus.i_wb1_addr : bus.i_wb0_addr;
        d   = g1 ? bus.i_wb1_data : bus.i_wb0_data;
        iss = bus.i_issue; rd = bus.i_issue_rd; v1 = bus.i_wb1_valid;
        @(posedge clk);
        if (g0 || g1) begin
            m_we = (a != 0); m_waddr = a; m_wdata = d; m_busy[a] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (iss && rd != 0) m_busy[rd] = 1'b1;
        if (v1 && !g1) m_age = (m_age < AGE_MAX) ? m_age + 1 : m_age;
        else           m_age = 0;
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_wb0_valid = 0; bus.i_wb0_addr = '0; bus.i_wb0_data = '0;
        bus.i_wb1_valid = 0; bus.i_wb1_addr = '0; bus.i_wb1_data = '0;
        bus.i_issue = 0; bus.i_issue_rd = '0;
        bus.i_re1 = 0; bus.i_re2 = 0; bus.i_raddr1 = '0; bus.i_raddr2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        checks++;
        if ({bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_busy} !== 70'd0) begin
            errors++;
            $display("FAIL reset_regs: got we=%b waddr=%0d wdata=%h busy=%h want all zero",
                     bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_busy);
        end
        checks++;
        if ({bus.o_wb0_ready, bus.o_wb1_ready, bus.o_stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb: got r0/r1/stall=%b want 000",
                     {bus.o_wb0_ready, bus.o_wb1_ready, bus.o_stall});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        bus.i_wb0_valid = 1; bus.i_wb0_addr = 5'd5; bus.i_wb0_data = 32'hA5A5_A5A5;
        #1;
        checks++;
        if ({bus.o_wb0_ready, bus.o_wb1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL basic_ready: got r0/r1=%b want 10", {bus.o_wb0_ready, bus.o_wb1_ready});
        end
        tick();
        checks++;
        if ({bus.o_we, bus.o_waddr, bus.o_wdata} !== {1'b1, 5'd5, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL basic_write: got we=%b waddr=%0d wdata=%h want 1/5/a5a5a5a5",
                     bus.o_we, bus.o_waddr, bus.o_wdata);
        end
        @(negedge clk);
        idle_inputs();
        tick();
        checks++;
        if ({bus.o_we, bus.o_waddr, bus.o_wdata} !== {1'b0, 5'd5, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL basic_hold: got we=%b waddr=%0d wdata=%h want 0/5/a5a5a5a5",
                     bus.o_we, bus.o_waddr, bus.o_wdata);
        end
    endtask

    task automatic test_priority();
        logic g0, g1;
        int first_g1 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            bus.i_wb0_valid = 1; bus.i_wb0_addr = 5'd3;
            bus.i_wb1_valid = 1; bus.i_wb1_addr = 5'd4; bus.i_wb1_data = 32'h4444_0000;
            if (bus.o_wb0_ready || cyc == 1) bus.i_wb0_data = $urandom;
            #1;
            model_grants(g0, g1);
            checks++;
            if ({bus.o_wb0_ready, bus.o_wb1_ready} !== {g0, g1}) begin
                errors++;
                $display("FAIL prio_grant cyc%0d: got r0/r1=%b want %b",
                         cyc, {bus.o_wb0_ready, bus.o_wb1_ready}, {g0, g1});
            end
            if (bus.o_wb1_ready && first_g1 == 0) first_g1 = cyc;
            tick();
            checks++;
            if ({bus.o_we, bus.o_waddr, bus.o_wdata} !== {m_we, m_waddr, m_wdata}) begin
                errors++;
                $display("FAIL prio_write cyc%0d: got %b/%0d/%h want %b/%0d/%h", cyc,
                         bus.o_we, bus.o_waddr, bus.o_wdata, m_we, m_waddr, m_wdata);
            end
        end
        checks++;
        if (first_g1 != (AGING ? MAX_WAIT + 1 : 0)) begin
            errors++;
            $display("FAIL prio_first_req1: got cycle %0d want %0d", first_g1, AGING ? MAX_WAIT + 1 : 0);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_raw_stall();
        @(negedge clk);
        idle_inputs();
        bus.i_issue = 1; bus.i_issue_rd = 5'd7;
        tick();
        @(negedge clk);
        bus.i_issue = 0; bus.i_re1 = 1; bus.i_raddr1 = 5'd7;
        #1;
        checks++;
        if (bus.o_stall !== 1'b1 || bus.o_busy[7] !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_set: got stall=%b busy7=%b want 1/1", bus.o_stall, bus.o_busy[7]);
        end
        tick();
        @(negedge clk);
        bus.i_wb1_valid = 1; bus.i_wb1_addr = 5'd7; bus.i_wb1_data = 32'h0000_7777;
        #1;
        checks++;
        if ({bus.o_wb1_ready, bus.o_stall} !== 2'b11) begin
            errors++;
            $display("FAIL raw_grant: got r1/stall=%b want 11", {bus.o_wb1_ready, bus.o_stall});
        end
        tick();
        checks++;
        if ({bus.o_we, bus.o_waddr, bus.o_stall, bus.o_busy[7]} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL raw_release: got we=%b waddr=%0d stall=%b busy7=%b want 1/7/0/0",
                     bus.o_we, bus.o_waddr, bus.o_stall, bus.o_busy[7]);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.i_wb0_valid = 1; bus.i_wb0_addr = 5'd0; bus.i_wb0_data = 32'hFFFF_FFFF;
        bus.i_issue = 1; bus.i_issue_rd = 5'd0;
        #1;
        checks++;
        if (bus.o_wb0_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b want 1", bus.o_wb0_ready);
        end
        tick();
        @(negedge clk);
        idle_inputs();
        bus.i_re1 = 1; bus.i_raddr1 = 5'd0; bus.i_re2 = 1; bus.i_raddr2 = 5'd0;
        #1;
        checks++;
        if ({bus.o_we, bus.o_stall, bus.o_busy} !== {1'b0, 1'b0, m_busy}) begin
            errors++;
            $display("FAIL x0_write: got we=%b stall=%b busy=%h want 0/0/%h",
                     bus.o_we, bus.o_stall, bus.o_busy, m_busy);
        end
        tick();
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        idle_inputs();
        bus.i_issue = 1; bus.i_issue_rd = 5'd9;
        bus.i_wb0_valid = 1; bus.i_wb0_addr = 5'd9; bus.i_wb0_data = 32'h0909_0909;
        tick();
        checks++;
        if ({bus.o_busy[9], bus.o_we, bus.o_waddr} !== {1'b1, 1'b1, 5'd9}) begin
            errors++;
            $display("FAIL set_wins: got busy9=%b we=%b waddr=%0d want 1/1/9",
                     bus.o_busy[9], bus.o_we, bus.o_waddr);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic g0, g1;
        logic p0 = 0, p1 = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!p0) begin
                bus.i_wb0_valid = ($urandom_range(0, 99) < 50);
                bus.i_wb0_addr  = 5'($urandom_range(0, 7));
                bus.i_wb0_data  = $urandom;
            end
            if (!p1) begin
                bus.i_wb1_valid = ($urandom_range(0, 99) < 60);
                bus.i_wb1_addr  = 5'($urandom_range(0, 7));
                bus.i_wb1_data  = $urandom;
            end
            bus.i_issue    = ($urandom_range(0, 99) < 35);
            bus.i_issue_rd = 5'($urandom_range(0, 7));
            bus.i_re1 = $urandom_range(0, 1) == 1; bus.i_raddr1 = 5'($urandom_range(0, 7));
            bus.i_re2 = $urandom_range(0, 1) == 1; bus.i_raddr2 = 5'($urandom_range(0, 7));
            #1;
            model_grants(g0, g1);
            checks++;
            if ({bus.o_wb0_ready, bus.o_wb1_ready, bus.o_stall} !== {g0, g1, model_stall()}) begin
                errors++;
                $display("FAIL rand_comb cyc%0d: got r0/r1/stall=%b want %b", cyc,
                         {bus.o_wb0_ready, bus.o_wb1_ready, bus.o_stall}, {g0, g1, model_stall()});
            end
            p0 = bus.i_wb0_valid && !g0;
            p1 = bus.i_wb1_valid && !g1;
            tick();
            checks++;
            if ({bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_busy} !== {m_we, m_waddr, m_wdata, m_busy}) begin
                errors++;
                $display("FAIL rand_regs cyc%0d: got %b/%0d/%h/%h want %b/%0d/%h/%h", cyc,
                         bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_busy, m_we, m_waddr, m_wdata, m_busy);
            end
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        bus.i_issue = 1; bus.i_issue_rd = 5'd12;
        bus.i_wb0_valid = 1; bus.i_wb0_addr = 5'd3; bus.i_wb0_data = 32'h3333_3333;
        bus.i_wb1_valid = 1; bus.i_wb1_addr = 5'd12; bus.i_wb1_data = 32'hC0C0_C0C0;
        tick();
        @(negedge clk);
        bus.i_issue = 0;
        tick();
        checks++;
        if ({bus.o_we, bus.o_busy[12]} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre: got we=%b busy12=%b want 1/1", bus.o_we, bus.o_busy[12]);
        end
        @(negedge clk);
        bus.i_wb0_valid = 0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.o_we, bus.o_busy, bus.o_waddr, bus.o_wdata} !== 70'd0) begin
            errors++;
            $display("FAIL rstmid_regs: got we=%b busy=%h waddr=%0d wdata=%h want all zero",
                     bus.o_we, bus.o_busy, bus.o_waddr, bus.o_wdata);
        end
`ifdef WB_AGING_EN
        checks++;
        if (dut.age_q !== '0) begin
            errors++;
            $display("FAIL rstmid_age: got %0d want 0", dut.age_q);
        end
`endif
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.o_we, bus.o_busy} !== 33'd0) begin
            errors++;
            $display("FAIL rstmid_after: got we=%b busy=%h want 0/0", bus.o_we, bus.o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_priority();
        test_raw_stall();
        test_x0();
        test_set_wins();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
